// File: rtl/fdr_pipe.sv
// WIDTH x DEPTH register pipeline with enable, sync flush, per-stage valid, run-time tap and fill count.
// Tap latency TAP+1 CE edges, combinational output mux, no backpressure; FDR_PIPE_PARITY_EN adds DPAR/PERR.
module fdr_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int TAPW  = 2
) (
  input  logic              CK,
  input  logic              nCL,
  input  logic              CE,
  input  logic              FLUSH,
  input  logic [WIDTH-1:0]  D,
  input  logic              VIN,
  input  logic [TAPW-1:0]   TAP,
`ifdef FDR_PIPE_PARITY_EN
  input  logic              DPAR,
`endif
  output logic [WIDTH-1:0]  Q,
  output logic              VLD,
  output logic [TAPW:0]     FILL,
  output logic              FULL,
  output logic              EMPTY
`ifdef FDR_PIPE_PARITY_EN
  ,
  output logic              PERR
`endif
);

  logic [WIDTH-1:0] stg [DEPTH];
  logic [DEPTH-1:0] v;
  logic [TAPW:0]    fill;
  logic [TAPW-1:0]  tap_c;

  // Out-of-range taps only exist for non-power-of-2 depths; pin them to the last stage.
  always_comb begin
    tap_c = TAP;
    if (32'(TAP) >= 32'(DEPTH))
      tap_c = TAPW'(DEPTH - 1);
  end

  always_ff @(posedge CK or negedge nCL) begin
    if (!nCL) begin
      for (int i = 0; i < DEPTH; i++)
        stg[i] <= '0;
      v    <= '0;
      fill <= '0;
    end else if (FLUSH) begin
      for (int i = 0; i < DEPTH; i++)
        stg[i] <= '0;
      v    <= '0;
      fill <= '0;
    end else if (CE) begin
      stg[0] <= D;
      for (int i = 1; i < DEPTH; i++)
        stg[i] <= stg[i-1];
      v <= {v[DEPTH-2:0], VIN};
      // Count tracks popcount(v): one enters at stage 0, one leaves past the last stage.
      case ({VIN, v[DEPTH-1]})
        2'b10:   fill <= fill + (TAPW+1)'(1);
        2'b01:   fill <= fill - (TAPW+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  assign Q     = stg[tap_c];
  assign VLD   = v[tap_c];
  assign FILL  = fill;
  assign FULL  = (fill == (TAPW+1)'(DEPTH));
  assign EMPTY = (fill == '0);

`ifdef FDR_PIPE_PARITY_EN
  logic [DEPTH-1:0] par;

  always_ff @(posedge CK or negedge nCL) begin
    if (!nCL)
      par <= '0;
    else if (FLUSH)
      par <= '0;
    else if (CE)
      par <= {par[DEPTH-2:0], DPAR};
  end

  // Producer supplies even parity, so any valid stage with odd combined parity is corrupt.
  assign PERR = VLD & (^Q ^ par[tap_c]);
`endif

endmodule

// File: tb/tb_fdr_pipe.sv
// Directed bench for fdr_pipe (WIDTH=4, DEPTH=4): reset, latency, fill, hold/flush, tap sweep, parity.
module tb_fdr_pipe;

  logic       CK = 1'b0;
  logic       nCL;
  logic       CE;
  logic       FLUSH;
  logic [3:0] D;
  logic       VIN;
  logic [1:0] TAP;
  logic [3:0] Q;
  logic       VLD;
  logic [2:0] FILL;
  logic       FULL;
  logic       EMPTY;
`ifdef FDR_PIPE_PARITY_EN
  logic       DPAR;
  logic       PERR;
`endif

  int checks = 0;
  int errors = 0;

  fdr_pipe #(.WIDTH(4), .DEPTH(4), .TAPW(2)) dut (
    .CK    (CK),
    .nCL   (nCL),
    .CE    (CE),
    .FLUSH (FLUSH),
    .D     (D),
    .VIN   (VIN),
    .TAP   (TAP),
`ifdef FDR_PIPE_PARITY_EN
    .DPAR  (DPAR),
`endif
    .Q     (Q),
    .VLD   (VLD),
    .FILL  (FILL),
    .FULL  (FULL),
    .EMPTY (EMPTY)
`ifdef FDR_PIPE_PARITY_EN
    ,
    .PERR  (PERR)
`endif
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle 1ns so outputs are sampled well away from the edge.
  task automatic step();
    @(posedge CK);
    #1;
  endtask

  logic [2:0] fill_exp [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
  logic [3:0] tap_vals [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
  logic [3:0] load_seq [4] = '{4'hD, 4'hC, 4'hB, 4'hA};

  initial begin
    nCL = 1'b0; CE = 1'b0; FLUSH = 1'b0; D = '0; VIN = 1'b0; TAP = '0;
`ifdef FDR_PIPE_PARITY_EN
    DPAR = 1'b0;
`endif
    #12;
    chk("rst_q", 32'(Q), 32'h0);
    chk("rst_vld", 32'(VLD), 32'h0);
    chk("rst_fill", 32'(FILL), 32'h0);
    chk("rst_empty", 32'(EMPTY), 32'h1);
    chk("rst_full", 32'(FULL), 32'h0);
    step();
    nCL = 1'b1;

    // Latency at TAP=2: first word shows after the 3rd edge.
    TAP = 2'd2; CE = 1'b1; VIN = 1'b1;
    D = 4'h1; step();
    D = 4'h2; step();
    chk("lat_e2_vld", 32'(VLD), 32'h0);
    D = 4'h3; step();
    chk("lat_e3_q", 32'(Q), 32'h1);
    chk("lat_e3_vld", 32'(VLD), 32'h1);
    D = 4'h4; step();
    chk("lat_e4_q", 32'(Q), 32'h2);
    chk("lat_e4_full", 32'(FULL), 32'h1);

    // Fill / drain counting.
    FLUSH = 1'b1; step(); FLUSH = 1'b0;
    chk("fl_fill0", 32'(FILL), 32'h0);
    VIN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      D = 4'(i); step();
      chk($sformatf("fill_up%0d", i), 32'(FILL), 32'(fill_exp[i]));
      chk($sformatf("full_up%0d", i), 32'(FULL), (i >= 3) ? 32'h1 : 32'h0);
    end
    VIN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("fill_dn%0d", i), 32'(FILL), 32'(3 - i));
    end
    chk("drain_empty", 32'(EMPTY), 32'h1);

    // Load A..D into stages 0..3, then sweep the tap without clocking.
    VIN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      D = load_seq[i]; step();
    end
    chk("load_full", 32'(FULL), 32'h1);
    CE = 1'b0;
    for (int t = 0; t < 4; t++) begin
      TAP = 2'(t); #1;
      chk($sformatf("tap%0d_q", t), 32'(Q), 32'(tap_vals[t]));
    end

    // CE low holds everything.
    TAP = 2'd3; D = 4'h5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold%0d_q", i), 32'(Q), 32'hD);
    end
    chk("hold_fill", 32'(FILL), 32'h4);

    // Flush beats CE and VIN.
    CE = 1'b1; VIN = 1'b1; FLUSH = 1'b1; step(); FLUSH = 1'b0;
    chk("flush_fill", 32'(FILL), 32'h0);
    chk("flush_q3", 32'(Q), 32'h0);
    TAP = 2'd0; #1;
    chk("flush_q0", 32'(Q), 32'h0);
    chk("flush_vld0", 32'(VLD), 32'h0);

    // Async clear mid-cycle, then normal reload.
    D = 4'h7; step(); step();
    chk("pre_rst_q", 32'(Q), 32'h7);
    #2 nCL = 1'b0; #1;
    chk("arst_q", 32'(Q), 32'h0);
    chk("arst_vld", 32'(VLD), 32'h0);
    chk("arst_fill", 32'(FILL), 32'h0);
    chk("arst_empty", 32'(EMPTY), 32'h1);
    #2 nCL = 1'b1;
    D = 4'h9; step();
    chk("post_rst_q", 32'(Q), 32'h9);
    chk("post_rst_fill", 32'(FILL), 32'h1);

    // Invalid data still shifts.
    VIN = 1'b0; D = 4'h6; step();
    chk("inv_q", 32'(Q), 32'h6);
    chk("inv_vld", 32'(VLD), 32'h0);
    chk("inv_fill", 32'(FILL), 32'h1);

`ifdef FDR_PIPE_PARITY_EN
    FLUSH = 1'b1; step(); FLUSH = 1'b0;
    TAP = 2'd0; VIN = 1'b1; D = 4'h3; DPAR = 1'b1; step();
    chk("perr_bad", 32'(PERR), 32'h1);
    DPAR = 1'b0; step();
    chk("perr_good", 32'(PERR), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
